// File: rtl/branch_predict_unit_pkg.sv
// Shared definitions for the branch predict unit: branch condition codes,
// saturating-counter reset/allocate values and BTB field width helpers.
package branch_predict_unit_pkg;

    // Branch condition encodings (RISC-V funct3)
    typedef enum logic [2:0] {
        BR_BEQ  = 3'b000,
        BR_BNE  = 3'b001,
        BR_BLT  = 3'b100,
        BR_BGE  = 3'b101,
        BR_BLTU = 3'b110,
        BR_BGEU = 3'b111
    } branch_type_e;

    // Weakly taken: MSB set, remaining bits clear
    function automatic int unsigned ctr_wt(input int unsigned bits);
        return 32'd1 << (bits - 1);
    endfunction

    // Weakly not-taken: MSB clear, remaining bits set
    function automatic int unsigned ctr_wnt(input int unsigned bits);
        return ctr_wt(bits) - 1;
    endfunction

    // Tag width once the index and the two byte-offset bits are removed
    function automatic int unsigned tag_width(input int unsigned xlen, input int unsigned entries);
        return xlen - $clog2(entries) - 2;
    endfunction

endpackage

// File: rtl/branch_predict_unit_if.sv
// Pipeline-facing bundle of the branch predict unit: IF lookup, EX resolution,
// redirect and performance counters. master = pipeline, slave = predictor.
interface branch_predict_unit_if #(
    parameter int unsigned XLEN = 32
);
    logic [XLEN-1:0] pc_F;
    logic            pred_taken_F;
    logic [XLEN-1:0] pred_target_F;
    logic            valid_E;
    logic            Branch_E;
    logic            Jal_E;
    logic            Jalr_E;
    logic [2:0]      BranchType_E;
    logic            Zero;
    logic            LessThan;
    logic            LessThanU;
    logic [XLEN-1:0] pc_E;
    logic [XLEN-1:0] imm_E;
    logic [XLEN-1:0] rs1_data_E;
    logic            pred_taken_E;
    logic [XLEN-1:0] pred_target_E;
    logic            PCSrc;
    logic [XLEN-1:0] PCTarget;
    logic [31:0]     br_count;
    logic [31:0]     mispred_count;

    modport master (
        output pc_F, valid_E, Branch_E, Jal_E, Jalr_E, BranchType_E,
               Zero, LessThan, LessThanU, pc_E, imm_E, rs1_data_E,
               pred_taken_E, pred_target_E,
        input  pred_taken_F, pred_target_F, PCSrc, PCTarget,
               br_count, mispred_count
    );

    modport slave (
        input  pc_F, valid_E, Branch_E, Jal_E, Jalr_E, BranchType_E,
               Zero, LessThan, LessThanU, pc_E, imm_E, rs1_data_E,
               pred_taken_E, pred_target_E,
        output pred_taken_F, pred_target_F, PCSrc, PCTarget,
               br_count, mispred_count
    );
endinterface

// File: rtl/branch_predict_unit_cond_eval.sv
// Combinational branch condition evaluation from the ALU compare flags.
module branch_cond_eval
    import branch_predict_unit_pkg::*;
(
    input  logic [2:0] branch_type,
    input  logic       zero,
    input  logic       less_than,
    input  logic       less_than_u,
    output logic       cond
);

    // Select the flag (or its inverse) named by the encoding; unknown codes never take
    always_comb begin
        cond = 1'b0;
        case (branch_type_e'(branch_type))
            BR_BEQ:  cond = zero;
            BR_BNE:  cond = ~zero;
            BR_BLT:  cond = less_than;
            BR_BGE:  cond = ~less_than;
            BR_BLTU: cond = less_than_u;
            BR_BGEU: cond = ~less_than_u;
            default: cond = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_predict_unit.sv
// Direct-mapped BTB with per-entry saturating counters. Predicts in IF,
// resolves in EX, redirects on mispredict and counts events.
module branch_predict_unit
    import branch_predict_unit_pkg::*;
#(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned BTB_ENTRIES = 16,
    parameter int unsigned CTR_BITS    = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    branch_predict_unit_if.slave bus
);

    localparam int unsigned IDXW = $clog2(BTB_ENTRIES);
    localparam int unsigned TAGW = tag_width(XLEN, BTB_ENTRIES);
    localparam logic [CTR_BITS-1:0] CTR_WT_V  = CTR_BITS'(ctr_wt(CTR_BITS));
    localparam logic [CTR_BITS-1:0] CTR_WNT_V = CTR_BITS'(ctr_wnt(CTR_BITS));
    localparam logic [XLEN-1:0]     PC_STEP   = XLEN'(4);

    // Table held in flops so the whole array can be cleared by the synchronous reset
    logic [BTB_ENTRIES-1:0] valid_q, valid_d;
    logic [BTB_ENTRIES-1:0] jump_q, jump_d;
    logic [TAGW-1:0]        tag_q    [BTB_ENTRIES];
    logic [TAGW-1:0]        tag_d    [BTB_ENTRIES];
    logic [XLEN-1:0]        target_q [BTB_ENTRIES];
    logic [XLEN-1:0]        target_d [BTB_ENTRIES];
    logic [CTR_BITS-1:0]    ctr_q    [BTB_ENTRIES];
    logic [CTR_BITS-1:0]    ctr_d    [BTB_ENTRIES];
    logic [31:0]            br_count_q, br_count_d;
    logic [31:0]            mispred_count_q, mispred_count_d;

    logic [IDXW-1:0] idx_f, idx_e;
    logic [TAGW-1:0] tag_f, tag_e;
    logic            hit_f, hit_e, pred_taken_f;
    logic            cond, act_taken, upd, pcsrc;
    logic [XLEN-1:0] act_tgt;

    branch_cond_eval u_cond (
        .branch_type (bus.BranchType_E),
        .zero        (bus.Zero),
        .less_than   (bus.LessThan),
        .less_than_u (bus.LessThanU),
        .cond        (cond)
    );

    // IF lookup: reads the registered table only, so a same-cycle write is not visible
    always_comb begin
        idx_f        = bus.pc_F[IDXW+1:2];
        tag_f        = bus.pc_F[XLEN-1:IDXW+2];
        hit_f        = valid_q[idx_f] && (tag_q[idx_f] == tag_f);
        pred_taken_f = hit_f && (jump_q[idx_f] || ctr_q[idx_f][CTR_BITS-1]);
        bus.pred_taken_F  = pred_taken_f;
        bus.pred_target_F = pred_taken_f ? target_q[idx_f] : bus.pc_F + PC_STEP;
    end

    // EX resolution and redirect decision
    always_comb begin
        act_taken = bus.valid_E && (bus.Jal_E || bus.Jalr_E || (bus.Branch_E && cond));
        act_tgt   = bus.Jalr_E ? ((bus.rs1_data_E + bus.imm_E) & {{(XLEN-1){1'b1}}, 1'b0})
                               : bus.pc_E + bus.imm_E;
        pcsrc     = bus.valid_E && ((act_taken != bus.pred_taken_E) ||
                                    (act_taken && (bus.pred_target_E != act_tgt)));
        bus.PCSrc    = pcsrc;
        bus.PCTarget = act_taken ? act_tgt : bus.pc_E + PC_STEP;
    end

    // Table update and event counters
    always_comb begin
        valid_d  = valid_q;
        jump_d   = jump_q;
        tag_d    = tag_q;
        target_d = target_q;
        ctr_d    = ctr_q;
        idx_e    = bus.pc_E[IDXW+1:2];
        tag_e    = bus.pc_E[XLEN-1:IDXW+2];
        hit_e    = valid_q[idx_e] && (tag_q[idx_e] == tag_e);
        upd      = bus.valid_E && (bus.Branch_E || bus.Jal_E || bus.Jalr_E);
        if (upd) begin
            if (hit_e) begin
                if (act_taken) begin
                    target_d[idx_e] = act_tgt;
                end
                if (bus.Branch_E) begin
                    if (act_taken && (ctr_q[idx_e] != '1)) begin
                        ctr_d[idx_e] = ctr_q[idx_e] + 1'b1;
                    end else if (!act_taken && (ctr_q[idx_e] != '0)) begin
                        ctr_d[idx_e] = ctr_q[idx_e] - 1'b1;
                    end
                end
            end else if (act_taken) begin
                valid_d[idx_e]  = 1'b1;
                tag_d[idx_e]    = tag_e;
                target_d[idx_e] = act_tgt;
                jump_d[idx_e]   = bus.Jal_E || bus.Jalr_E;
                ctr_d[idx_e]    = CTR_WT_V;
            end
        end
        br_count_d      = br_count_q + 32'(upd);
        mispred_count_d = mispred_count_q + 32'(pcsrc);
        bus.br_count      = br_count_q;
        bus.mispred_count = mispred_count_q;
    end

    // State registers; tag/target/jump need no reset because valid gates them
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q         <= '0;
            br_count_q      <= '0;
            mispred_count_q <= '0;
            for (int unsigned i = 0; i < BTB_ENTRIES; i++) begin
                ctr_q[i] <= CTR_WNT_V;
            end
        end else begin
            valid_q         <= valid_d;
            jump_q          <= jump_d;
            tag_q           <= tag_d;
            target_q        <= target_d;
            ctr_q           <= ctr_d;
            br_count_q      <= br_count_d;
            mispred_count_q <= mispred_count_d;
        end
    end

endmodule
